oscillation_monitor: RTL and testbench
======================================

# oscillation_monitor

Synthesizable, parametrised on-chip measurement block for the phi_n neural processor. Over a programmable window of 4 kHz update strobes it measures, per channel:
- oscillation peak count, with hysteresis;
- signal span (max − min).

It then issues a per-channel pass/fail verdict against programmable bounds. It sits beside the oscillator bank, taps theta, L2/3, DAC-path and similar signals, and makes oscillator-health checks available in hardware and in long regressions, with one-shot or continuous windows.

## Interface
- WIDTH, 18, signed sample width (Q4.14).
- NUM_CH, 4, number of monitored channels.
- WINDOW, 4000, window length in clk_4khz_en strobes (≥ 1).
- CNT_W, 16, peak counter width per channel; the counter saturates.
- clk  in  1  system clock (125 MHz).
- rst  in  1  synchronous, active-high reset.
- clk_4khz_en  in  1  one-cycle sample strobe.
- samples  in  NUM_CH*WIDTH  signed samples; channel i is bits [i*WIDTH +: WIDTH].
- thr_hi, thr_lo  in  WIDTH each  signed hysteresis thresholds.
- peak_min, peak_max  in  CNT_W each  inclusive pass bounds on peak count.
- span_min  in  WIDTH+1  minimum unsigned span required for pass.
- continuous  in  1  when set, re-arm automatically after each window.
- start  in  1  one-cycle request to begin a window.
- abort  in  1  cancel the window in progress.
- busy  out  1  high in ARM, MEASURE and LATCH.
- done  out  1  one-cycle pulse when results update.
- peak_count  out  NUM_CH*CNT_W  per-channel peak counts from the last completed window.
- span  out  NUM_CH*(WIDTH+1)  per-channel unsigned max − min from the last completed window.
- pass_mask  out  NUM_CH  per-channel verdict.

## Operation
- **FSM states:** IDLE → ARM → MEASURE → LATCH → DONE.
- **IDLE**
  - start=1 → ARM.
  - start is ignored in every other state.
- **ARM** (exactly 1 cycle)
  - Latch thr_hi, thr_lo, peak_min, peak_max, span_min and continuous. Input changes later in the window have no effect.
  - Clear the accumulators and the strobe counter.
  - Clear every channel's `high` flag.
  - A strobe arriving in this cycle is not counted.
- **MEASURE**, on each clk_4khz_en, per channel with sample s:
  - If s > thr_hi and high=0: peak count +1 (saturating at 2^CNT_W−1), then high=1.
  - Then, if s < thr_lo: high=0. Both rules apply in order in the same strobe.
  - The first strobe seeds min=max=s. Later strobes update min and max with signed compare.
  - The strobe counter increments. When the counter reaches WINDOW, the FSM goes to LATCH on the next cycle.
- **LATCH**
  - span = max − min, computed in WIDTH+1 bits, unsigned.
  - pass[i] = (peak_min ≤ peak[i] ≤ peak_max) && (span[i] ≥ span_min).
  - A channel whose samples never changed has span 0.
- **DONE** (1 cycle)
  - peak_count, span and pass_mask are register-loaded on entry; done=1.
  - Next state is ARM if the latched continuous=1, otherwise IDLE.
- **abort:** in ARM, MEASURE or LATCH → IDLE next cycle. No done pulse; published outputs keep their previous values. abort in IDLE or DONE has no effect.
- **Simultaneous start and abort in IDLE:** start wins.

## Timing
- **Reset:** every output is 0 and the state is IDLE. This holds mid-window too: reset discards all partial results.
- **start:** start at cycle t → busy=1 from cycle t+1.
- **End of window:** the WINDOW-th strobe at cycle u gives LATCH at u+1 and done/outputs at u+2.
- **busy:** falls at u+2 in one-shot mode; stays high in continuous mode.
- **Continuous mode:** the next ARM is at u+3. A strobe at u+1, u+2 or u+3 is not counted.
- **Output stability:** outputs hold between done pulses.
- **Data path:** no combinational path from samples to any output.

## Test plan
All scenarios use NUM_CH=2, WINDOW=1000, thr_hi=12000, thr_lo=8000, peak 4..8, span_min=1000 unless stated.

- **Nominal:**
  - ch0 is a square wave of period 200 strobes, low 0 for the first 100 strobes, then high 15000.
  - ch1 is held at constant 5000.
  - Required: peak_count = {0, 5}, span = {0, 15000}, pass_mask = 2'b01, done is a single pulse 2 cycles after the 1000th strobe.
- **Hysteresis:**
  - ch0 alternates 13000 and 10000 every strobe → peak 1, span 3000, fail.
  - Changing the sequence to alternate with 7000 instead gives peak 500 and fail (above peak_max).
- **Saturation:**
  - With CNT_W=3, ch0 toggles 15000/0 every 10 strobes → peak_count 7.
- **Abort / reset:**
  - abort at strobe 500 → no done and outputs unchanged; a new start then completes normally.
  - rst at strobe 500 → all outputs 0, state IDLE.
- **Continuous and threshold latching:**
  - continuous=1 → consecutive done pulses 1003 strobes apart (strobe every cycle); busy never drops.
  - thr_hi changed mid-window has no effect until the next ARM.
- **Negative samples:**
  - ch1 swings −20000..−5000 → span 15000, peak 0, fail.

Source files
------------

// File: rtl/oscillation_monitor_if.sv
`timescale 1ns/1ps
// Bus bundle for oscillation_monitor: sample strobe/data, window configuration,
// control requests and the published per-channel results.
interface oscillation_monitor_if #(
  parameter int WIDTH  = 18,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  // Control protocol: start is a one-cycle request honoured only while idle
  // (it wins over a simultaneous abort there). abort cancels an armed or running
  // window without publishing anything. done is a one-cycle pulse marking the
  // cycle in which peak_count/span/pass_mask take new values; those outputs then
  // hold until the next done pulse. busy covers ARM, MEASURE and LATCH, and also
  // the DONE cycle when the window re-arms itself.
  // dbg_state encoding: 0 IDLE, 1 ARM, 2 MEASURE, 3 LATCH, 4 DONE.
  logic                       clk_4khz_en;
  logic [NUM_CH*WIDTH-1:0]    samples;
  logic [WIDTH-1:0]           thr_hi;
  logic [WIDTH-1:0]           thr_lo;
  logic [CNT_W-1:0]           peak_min;
  logic [CNT_W-1:0]           peak_max;
  logic [WIDTH:0]             span_min;
  logic                       continuous;
  logic                       start;
  logic                       abort;
  logic                       busy;
  logic                       done;
  logic [NUM_CH*CNT_W-1:0]    peak_count;
  logic [NUM_CH*(WIDTH+1)-1:0] span;
  logic [NUM_CH-1:0]          pass_mask;
  logic [2:0]                 dbg_state;

  modport master (
    output clk_4khz_en, samples, thr_hi, thr_lo, peak_min, peak_max, span_min,
           continuous, start, abort,
    input  busy, done, peak_count, span, pass_mask, dbg_state
  );

  modport slave (
    input  clk_4khz_en, samples, thr_hi, thr_lo, peak_min, peak_max, span_min,
           continuous, start, abort,
    output busy, done, peak_count, span, pass_mask, dbg_state
  );
endinterface

// File: rtl/oscillation_monitor.sv
`timescale 1ns/1ps
// Windowed oscillator health monitor: per channel it counts hysteresis peaks
// and tracks signed min/max over WINDOW sample strobes, then publishes the
// peak count, the unsigned span and a pass/fail verdict against latched bounds.
module oscillation_monitor #(
  parameter int WIDTH  = 18,
  parameter int NUM_CH = 4,
  parameter int WINDOW = 4000,
  parameter int CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst,
  oscillation_monitor_if.slave bus
);
  localparam int SW = WIDTH + 1;
  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_MEASURE = 3'd2,
    S_LATCH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Configuration captured in ARM so mid-window input changes are ignored
  logic signed [WIDTH-1:0] r_thr_hi;
  logic signed [WIDTH-1:0] r_thr_lo;
  logic [CNT_W-1:0]        r_peak_min;
  logic [CNT_W-1:0]        r_peak_max;
  logic [WIDTH:0]          r_span_min;
  logic                    r_cont;

  // Window accumulators
  logic [CW-1:0]           r_strb_cnt;
  logic [CNT_W-1:0]        r_peak [NUM_CH];
  logic signed [WIDTH-1:0] r_min  [NUM_CH];
  logic signed [WIDTH-1:0] r_max  [NUM_CH];
  logic [NUM_CH-1:0]       r_high;

  // Published results
  logic [NUM_CH*CNT_W-1:0] r_peak_count;
  logic [NUM_CH*SW-1:0]    r_span;
  logic [NUM_CH-1:0]       r_pass_mask;

  logic                    w_strobe;
  logic                    w_last;
  logic                    w_busy;
  logic                    w_done;
  logic signed [WIDTH-1:0] w_sample   [NUM_CH];
  logic [CNT_W-1:0]        w_peak_nxt [NUM_CH];
  logic signed [WIDTH-1:0] w_min_nxt  [NUM_CH];
  logic signed [WIDTH-1:0] w_max_nxt  [NUM_CH];
  logic [NUM_CH-1:0]       w_high_nxt;
  logic [SW-1:0]           w_span     [NUM_CH];
  logic [NUM_CH-1:0]       w_pass;

  assign w_strobe = (r_state == S_MEASURE) && bus.clk_4khz_en;
  assign w_last   = w_strobe && (r_strb_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; abort outranks everything except a start in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.start) w_next_state = S_ARM;
      S_ARM:     w_next_state = bus.abort ? S_IDLE : S_MEASURE;
      S_MEASURE: begin
        if (bus.abort)   w_next_state = S_IDLE;
        else if (w_last) w_next_state = S_LATCH;
      end
      S_LATCH:   w_next_state = bus.abort ? S_IDLE : S_DONE;
      S_DONE:    w_next_state = r_cont ? S_ARM : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // State-decoded outputs; busy bridges DONE when the window re-arms itself
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_ARM, S_MEASURE, S_LATCH: w_busy = 1'b1;
      S_DONE: begin
        w_done = 1'b1;
        w_busy = r_cont;
      end
      default: ;
    endcase
  end

  // Per-channel peak/extreme update for the current strobe and span/verdict
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sample[i]   = $signed(bus.samples[i*WIDTH +: WIDTH]);
      w_peak_nxt[i] = r_peak[i];
      w_high_nxt[i] = r_high[i];
      // Rising through thr_hi counts once; falling below thr_lo re-arms
      if ((w_sample[i] > r_thr_hi) && !r_high[i]) begin
        if (r_peak[i] != {CNT_W{1'b1}}) w_peak_nxt[i] = r_peak[i] + 1'b1;
        w_high_nxt[i] = 1'b1;
      end
      if (w_sample[i] < r_thr_lo) w_high_nxt[i] = 1'b0;
      // The first strobe of a window seeds both extremes
      if (r_strb_cnt == '0) begin
        w_min_nxt[i] = w_sample[i];
        w_max_nxt[i] = w_sample[i];
      end else begin
        w_min_nxt[i] = (w_sample[i] < r_min[i]) ? w_sample[i] : r_min[i];
        w_max_nxt[i] = (w_sample[i] > r_max[i]) ? w_sample[i] : r_max[i];
      end
      // Sign-extended subtraction cannot overflow and max >= min always
      w_span[i] = {r_max[i][WIDTH-1], r_max[i]} - {r_min[i][WIDTH-1], r_min[i]};
      w_pass[i] = (r_peak[i] >= r_peak_min) && (r_peak[i] <= r_peak_max) &&
                  (w_span[i] >= r_span_min);
    end
  end

  // Datapath: configuration latch, accumulation and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      r_thr_hi     <= '0;
      r_thr_lo     <= '0;
      r_peak_min   <= '0;
      r_peak_max   <= '0;
      r_span_min   <= '0;
      r_cont       <= 1'b0;
      r_strb_cnt   <= '0;
      r_high       <= '0;
      r_peak_count <= '0;
      r_span       <= '0;
      r_pass_mask  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_peak[i] <= '0;
        r_min[i]  <= '0;
        r_max[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_ARM: begin
          r_thr_hi   <= $signed(bus.thr_hi);
          r_thr_lo   <= $signed(bus.thr_lo);
          r_peak_min <= bus.peak_min;
          r_peak_max <= bus.peak_max;
          r_span_min <= bus.span_min;
          r_cont     <= bus.continuous;
          r_strb_cnt <= '0;
          r_high     <= '0;
          for (int i = 0; i < NUM_CH; i++) begin
            r_peak[i] <= '0;
            r_min[i]  <= '0;
            r_max[i]  <= '0;
          end
        end
        S_MEASURE: begin
          if (w_strobe) begin
            r_strb_cnt <= r_strb_cnt + 1'b1;
            r_high     <= w_high_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
              r_peak[i] <= w_peak_nxt[i];
              r_min[i]  <= w_min_nxt[i];
              r_max[i]  <= w_max_nxt[i];
            end
          end
        end
        S_LATCH: begin
          // Loaded on the edge into DONE; an abort here leaves results untouched
          if (!bus.abort) begin
            for (int i = 0; i < NUM_CH; i++) begin
              r_peak_count[i*CNT_W +: CNT_W] <= r_peak[i];
              r_span[i*SW +: SW]             <= w_span[i];
            end
            r_pass_mask <= w_pass;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.peak_count = r_peak_count;
  assign bus.span       = r_span;
  assign bus.pass_mask  = r_pass_mask;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_oscillation_monitor.sv
`timescale 1ns/1ps
// Bench for oscillation_monitor: pattern table, randomized windows against a
// reference model, and hand-written abort/reset/continuous sequences.
module tb_oscillation_monitor;
  localparam int WIDTH  = 18;
  localparam int NUM_CH = 2;
  localparam int WINDOW = 1000;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;
  localparam int JUNK   = 30000;

  typedef struct packed {
    logic [SAT_W-1:0] sp1;
    logic [SAT_W-1:0] sp0;
    logic [1:0]       pass;
    logic [18:0]      span1;
    logic [18:0]      span0;
    logic [15:0]      peak1;
    logic [15:0]      peak0;
  } res_t;
  localparam int RES_W = $bits(res_t);

  typedef struct {
    int         pat;
    int         gap;
    int         peak0;
    int         peak1;
    int         span0;
    int         span1;
    logic [1:0] pass;
    int         sp0;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oscillation_monitor_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) ifm ();
  oscillation_monitor_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(SAT_W)) ifs ();

  assign ifs.clk_4khz_en = ifm.clk_4khz_en;
  assign ifs.samples     = ifm.samples;
  assign ifs.thr_hi      = ifm.thr_hi;
  assign ifs.thr_lo      = ifm.thr_lo;
  assign ifs.peak_min    = ifm.peak_min[SAT_W-1:0];
  assign ifs.peak_max    = ifm.peak_max[SAT_W-1:0];
  assign ifs.span_min    = ifm.span_min;
  assign ifs.continuous  = ifm.continuous;
  assign ifs.start       = ifm.start;
  assign ifs.abort       = ifm.abort;

  oscillation_monitor #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .WINDOW(WINDOW), .CNT_W(CNT_W))
    u_dut (.clk(clk), .rst(rst), .bus(ifm.slave));
  oscillation_monitor #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .WINDOW(WINDOW), .CNT_W(SAT_W))
    u_sat (.clk(clk), .rst(rst), .bus(ifs.slave));

  // ---------------- bench state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int smp [2][WINDOW];
  int cfg_thr_hi = 12000, cfg_thr_lo = 8000, cfg_pmin = 4, cfg_pmax = 8, cfg_smin = 1000;
  logic [RES_W-1:0] exp_q [$];
  res_t last_exp;
  vec_t vecs [5];

  // Done/busy monitor sampled on the falling edge
  int cyc = 0, done_cnt = 0, last_done_cyc = 0, done_gap = 0, busy_drops = 0;
  bit cont_watch = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (ifm.done) begin
      done_cnt++;
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
    end
    if (cont_watch && !ifm.busy) busy_drops++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [NUM_CH*WIDTH-1:0] pack2(input int a, input int b);
    logic [31:0] ta, tb;
    ta = a;
    tb = b;
    return {tb[WIDTH-1:0], ta[WIDTH-1:0]};
  endfunction

  task automatic apply_cfg();
    logic [31:0] t;
    t = cfg_thr_hi; ifm.thr_hi   = t[WIDTH-1:0];
    t = cfg_thr_lo; ifm.thr_lo   = t[WIDTH-1:0];
    t = cfg_pmin;   ifm.peak_min = t[CNT_W-1:0];
    t = cfg_pmax;   ifm.peak_max = t[CNT_W-1:0];
    t = cfg_smin;   ifm.span_min = t[WIDTH:0];
  endtask

  task automatic fill_pattern(input int pat);
    for (int k = 0; k < WINDOW; k++) begin
      int s0, s1;
      s1 = 5000;
      case (pat)
        1:       s0 = (k % 2 == 0) ? 13000 : 10000;
        2:       s0 = (k % 2 == 0) ? 13000 : 7000;
        3:       s0 = ((k / 10) % 2 == 0) ? 15000 : 0;
        default: s0 = ((k / 100) % 2 == 1) ? 15000 : 0;
      endcase
      if (pat == 4) s1 = (k % 2 == 0) ? -20000 : -5000;
      smp[0][k] = s0;
      smp[1][k] = s1;
    end
  endtask

  function automatic res_t mk_res(input int p0, input int p1, input int s0, input int s1,
                                  input logic [1:0] ps, input int q0, input int q1);
    res_t r;
    r.peak0 = 16'(p0); r.peak1 = 16'(p1);
    r.span0 = 19'(s0); r.span1 = 19'(s1);
    r.pass  = ps;
    r.sp0   = SAT_W'(q0); r.sp1 = SAT_W'(q1);
    return r;
  endfunction

  // Reference: walk the window's samples with plain integers
  function automatic res_t model();
    int n [2];
    int sp [2];
    logic [1:0] ps;
    for (int ch = 0; ch < 2; ch++) begin
      bit high = 1'b0;
      int mn = smp[ch][0];
      int mx = smp[ch][0];
      n[ch] = 0;
      for (int k = 0; k < WINDOW; k++) begin
        if (smp[ch][k] > cfg_thr_hi && !high) begin
          n[ch]++;
          high = 1'b1;
        end
        if (smp[ch][k] < cfg_thr_lo) high = 1'b0;
        if (smp[ch][k] < mn) mn = smp[ch][k];
        if (smp[ch][k] > mx) mx = smp[ch][k];
      end
      sp[ch] = mx - mn;
      ps[ch] = (n[ch] >= cfg_pmin) && (n[ch] <= cfg_pmax) && (sp[ch] >= cfg_smin);
    end
    return mk_res(n[0], n[1], sp[0], sp[1], ps,
                  (n[0] > 7) ? 7 : n[0], (n[1] > 7) ? 7 : n[1]);
  endfunction

  // Drive strobes k0..k1-1; poke 1 raises start mid-window, poke 2 changes
  // thr_hi and continuous mid-window
  task automatic drive_strobes(input int k0, input int k1, input int gap_max, input int poke);
    for (int k = k0; k < k1; k++) begin
      ifm.samples     = pack2(smp[0][k], smp[1][k]);
      ifm.clk_4khz_en = 1'b1;
      if (poke == 1 && k == 300) ifm.start = 1'b1;
      if (poke == 2 && k == 500) begin
        ifm.thr_hi     = 18'd20000;
        ifm.continuous = 1'b0;
      end
      tick();
      ifm.start = 1'b0;
      if (gap_max > 0 && k != WINDOW - 1) begin
        int g;
        g = $urandom_range(0, gap_max);
        ifm.clk_4khz_en = 1'b0;
        ifm.samples     = pack2(JUNK, JUNK);
        repeat (g) tick();
      end
    end
  endtask

  task automatic run_window(input string tag, input bit do_start, input res_t exp,
                            input logic exp_cont, input int gap_max, input int poke);
    res_t r;
    exp_q.push_back(exp);
    if (do_start) begin
      ifm.start = 1'b1;
      tick();
      ifm.start = 1'b0;
    end
    check({tag, "_arm_state"}, 64'(ifm.dbg_state), 64'd1);
    check({tag, "_arm_busy"}, 64'(ifm.busy), 64'd1);
    // A strobe during ARM must not be counted
    ifm.clk_4khz_en = 1'b1;
    ifm.samples     = pack2(JUNK, JUNK);
    tick();
    drive_strobes(0, WINDOW, gap_max, poke);
    // cycle u+1: LATCH, strobe here is ignored
    ifm.clk_4khz_en = 1'b1;
    ifm.samples     = pack2(JUNK, JUNK);
    check({tag, "_latch_state"}, 64'(ifm.dbg_state), 64'd3);
    check({tag, "_early_done"}, 64'(ifm.done), 64'd0);
    tick();
    // cycle u+2: DONE with fresh results
    check({tag, "_done"}, 64'(ifm.done), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      r = res_t'(exp_q.pop_front());
      check({tag, "_peak0"}, 64'(ifm.peak_count[15:0]), 64'(r.peak0));
      check({tag, "_peak1"}, 64'(ifm.peak_count[31:16]), 64'(r.peak1));
      check({tag, "_span0"}, 64'(ifm.span[18:0]), 64'(r.span0));
      check({tag, "_span1"}, 64'(ifm.span[37:19]), 64'(r.span1));
      check({tag, "_pass"}, 64'(ifm.pass_mask), 64'(r.pass));
      check({tag, "_satpeak"}, 64'(ifs.peak_count), 64'({r.sp1, r.sp0}));
      last_exp = r;
    end
    check({tag, "_done_busy"}, 64'(ifm.busy), 64'(exp_cont));
    tick();
    // cycle u+3: single done pulse; ARM again only in continuous mode
    check({tag, "_done_pulse"}, 64'(ifm.done), 64'd0);
    check({tag, "_post_busy"}, 64'(ifm.busy), 64'(exp_cont));
    ifm.clk_4khz_en = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    res_t nom;
    int d0;
    ifm.clk_4khz_en = 1'b0;
    ifm.samples     = '0;
    ifm.continuous  = 1'b0;
    ifm.start       = 1'b0;
    ifm.abort       = 1'b0;
    apply_cfg();
    repeat (3) tick();
    check("rst_state", 64'(ifm.dbg_state), 64'd0);
    check("rst_busy", 64'(ifm.busy), 64'd0);
    check("rst_done", 64'(ifm.done), 64'd0);
    check("rst_peak", 64'(ifm.peak_count), 64'd0);
    check("rst_span", 64'(ifm.span), 64'd0);
    check("rst_pass", 64'(ifm.pass_mask), 64'd0);
    rst = 1'b0;
    tick();

    // pat, gap, peak0, peak1, span0, span1, pass, sat peak0
    vecs[0] = '{0, 0,   5, 0, 15000,     0, 2'b01, 5};
    vecs[1] = '{1, 2,   1, 0,  3000,     0, 2'b00, 1};
    vecs[2] = '{2, 1, 500, 0,  6000,     0, 2'b00, 7};
    vecs[3] = '{3, 0,  50, 0, 15000,     0, 2'b00, 7};
    vecs[4] = '{4, 1,   5, 0, 15000, 15000, 2'b01, 5};
    for (int i = 0; i < 5; i++) begin
      fill_pattern(vecs[i].pat);
      apply_cfg();
      run_window($sformatf("vec%0d", i), 1'b1,
                 mk_res(vecs[i].peak0, vecs[i].peak1, vecs[i].span0, vecs[i].span1,
                        vecs[i].pass, vecs[i].sp0, 0),
                 1'b0, vecs[i].gap, 0);
    end

    // Randomized windows against the reference model
    for (int r = 0; r < 4; r++) begin
      cfg_thr_hi = $urandom_range(0, 20000);
      cfg_thr_lo = cfg_thr_hi - int'($urandom_range(0, 15000));
      cfg_pmin   = $urandom_range(0, 300);
      cfg_pmax   = cfg_pmin + int'($urandom_range(0, 300));
      cfg_smin   = $urandom_range(0, 70000);
      for (int k = 0; k < WINDOW; k++) begin
        smp[0][k] = int'($urandom_range(0, 60000)) - 30000;
        smp[1][k] = int'($urandom_range(0, 30000)) - 25000;
      end
      apply_cfg();
      run_window($sformatf("rnd%0d", r), 1'b1, model(), 1'b0, $urandom_range(0, 2), 0);
    end
    cfg_thr_hi = 12000; cfg_thr_lo = 8000; cfg_pmin = 4; cfg_pmax = 8; cfg_smin = 1000;
    apply_cfg();

    // Abort at strobe 500: no done, results unchanged
    fill_pattern(0);
    ifm.start = 1'b1;
    tick();
    ifm.start = 1'b0;
    tick();
    drive_strobes(0, 500, 0, 0);
    d0 = done_cnt;
    ifm.clk_4khz_en = 1'b0;
    ifm.abort       = 1'b1;
    tick();
    ifm.abort = 1'b0;
    check("abort_state", 64'(ifm.dbg_state), 64'd0);
    check("abort_busy", 64'(ifm.busy), 64'd0);
    repeat (5) tick();
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    check("abort_peak_hold", 64'(ifm.peak_count), 64'({last_exp.peak1, last_exp.peak0}));
    check("abort_span_hold", 64'(ifm.span), 64'({last_exp.span1, last_exp.span0}));
    check("abort_pass_hold", 64'(ifm.pass_mask), 64'(last_exp.pass));

    // start together with abort in IDLE: start wins; a stray start mid-window is ignored
    nom = mk_res(5, 0, 15000, 0, 2'b01, 5, 0);
    ifm.start = 1'b1;
    ifm.abort = 1'b1;
    tick();
    ifm.start = 1'b0;
    ifm.abort = 1'b0;
    run_window("restart", 1'b0, nom, 1'b0, 0, 1);

    // Reset mid-window discards everything
    ifm.start = 1'b1;
    tick();
    ifm.start = 1'b0;
    tick();
    drive_strobes(0, 500, 0, 0);
    ifm.clk_4khz_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state", 64'(ifm.dbg_state), 64'd0);
    check("mrst_busy", 64'(ifm.busy), 64'd0);
    check("mrst_peak", 64'(ifm.peak_count), 64'd0);
    check("mrst_span", 64'(ifm.span), 64'd0);
    check("mrst_pass", 64'(ifm.pass_mask), 64'd0);
    tick();
    check("mrst_idle", 64'(ifm.dbg_state), 64'd0);

    // Continuous mode; thr_hi/continuous changed mid-window take effect next ARM
    ifm.continuous = 1'b1;
    ifm.start      = 1'b1;
    tick();
    ifm.start  = 1'b0;
    cont_watch = 1'b1;
    run_window("cont1", 1'b0, nom, 1'b1, 0, 2);
    cont_watch = 1'b0;
    run_window("cont2", 1'b0, mk_res(0, 0, 15000, 0, 2'b00, 0, 0), 1'b0, 0, 0);
    check("cont_done_gap", 64'(done_gap), 64'd1003);
    check("cont_busy_drops", 64'(busy_drops), 64'd0);
    check("cont_end_idle", 64'(ifm.dbg_state), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
